// File: rtl/program_memory_arbiter.sv
// Two-way round-robin arbiter sharing one single-port program memory between the
// CPU instruction and data masters. Optional write protection: PMA_WRITE_PROTECT_EN.
module program_memory_arbiter #(
   parameter int                ADDR_W   = 13,
   parameter int                DATA_W   = 32,
   parameter int                CNT_W    = 16,
   parameter logic [ADDR_W-1:0] WP_LIMIT = 13'h1000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  freeze,
   input  logic                  i_read,
   input  logic [ADDR_W-1:0]     i_address,
   output logic                  i_waitrequest,
   output logic                  i_readdatavalid,
   output logic [DATA_W-1:0]     i_readdata,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_W-1:0]     d_address,
   input  logic [DATA_W/8-1:0]   d_byteenable,
   input  logic [DATA_W-1:0]     d_writedata,
   output logic                  d_waitrequest,
   output logic                  d_readdatavalid,
   output logic [DATA_W-1:0]     d_readdata,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   input  logic [DATA_W-1:0]     mem_readdata,
   output logic [CNT_W-1:0]      contention_count,
   input  logic                  wp_clear,
   output logic                  wp_violation
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_e;

   grant_e            lastGrant_q, lastGrant_d;
   logic              iRvalid_q, iRvalid_d;
   logic              dRvalid_q, dRvalid_d;
   logic [CNT_W-1:0]  contCnt_q, contCnt_d;
   logic              iReq, dReq, grantI, grantD, wpBlock;

   // A tie goes to whichever port did not win last time.
   always_comb begin
      iReq   = i_read;
      dReq   = d_read | d_write;
      grantI = 1'b0;
      grantD = 1'b0;
      if (!freeze) begin
         if (iReq && (!dReq || lastGrant_q == GRANT_D)) begin
            grantI = 1'b1;
         end else if (dReq) begin
            grantD = 1'b1;
         end
      end
   end

`ifdef PMA_WRITE_PROTECT_EN
   logic wpViol_q, wpViol_d;

   always_comb begin
      wpBlock  = grantD & d_write & (d_address < WP_LIMIT);
      wpViol_d = wpViol_q;
      if (wpBlock) begin
         wpViol_d = 1'b1;
      end else if (wp_clear) begin
         wpViol_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wpViol_q <= 1'b0;
      end else begin
         wpViol_q <= wpViol_d;
      end
   end

   assign wp_violation = wpViol_q;
`else
   logic unusedWp;

   assign unusedWp     = wp_clear ^ (^WP_LIMIT);
   assign wpBlock      = 1'b0;
   assign wp_violation = 1'b0;
`endif

   // A write blocked by protection is still acknowledged but never reaches the memory.
   always_comb begin
      mem_address    = grantD ? d_address : i_address;
      mem_byteenable = grantD ? d_byteenable : {BE_W{1'b1}};
      mem_writedata  = d_writedata;
      mem_chipselect = grantI | (grantD & ~wpBlock);
      mem_write      = grantD & d_write & ~wpBlock;
      i_waitrequest  = ~grantI;
      d_waitrequest  = ~grantD;
   end

   always_comb begin
      lastGrant_d = lastGrant_q;
      if (grantI) begin
         lastGrant_d = GRANT_I;
      end else if (grantD) begin
         lastGrant_d = GRANT_D;
      end
      iRvalid_d = grantI;
      dRvalid_d = grantD & ~d_write;
      contCnt_d = contCnt_q;
      if (!freeze && iReq && dReq && (contCnt_q != {CNT_W{1'b1}})) begin
         contCnt_d = contCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lastGrant_q <= GRANT_D;
         iRvalid_q   <= 1'b0;
         dRvalid_q   <= 1'b0;
         contCnt_q   <= '0;
      end else begin
         lastGrant_q <= lastGrant_d;
         iRvalid_q   <= iRvalid_d;
         dRvalid_q   <= dRvalid_d;
         contCnt_q   <= contCnt_d;
      end
   end

   assign i_readdatavalid  = iRvalid_q;
   assign d_readdatavalid  = dRvalid_q;
   assign i_readdata       = mem_readdata;
   assign d_readdata       = mem_readdata;
   assign contention_count = contCnt_q;

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Directed, table-driven bench for program_memory_arbiter with a behavioural
// 8192x32 memory; write-protect checks follow PMA_WRITE_PROTECT_EN.
module tb_program_memory_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        freeze, i_read, d_read, d_write, wp_clear;
   logic [12:0] i_address, d_address;
   logic [3:0]  d_byteenable;
   logic [31:0] d_writedata;
   logic        i_waitrequest, i_readdatavalid, d_waitrequest, d_readdatavalid;
   logic [31:0] i_readdata, d_readdata;
   logic [12:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write;
   logic [31:0] mem_writedata, mem_readdata;
   logic [15:0] contention_count;
   logic        wp_violation;

   logic        sIWait, sIRv, sDWait, sDRv, sCs, sWe, sWp;
   logic [31:0] sIRdata, sDRdata, sWdata;
   logic [12:0] sAddr;
   logic [3:0]  sBe;
   logic [3:0]  sCount;

   logic [31:0] memArr [8192];

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   program_memory_arbiter dut (
      .clk(clk), .reset_n(reset_n), .freeze(freeze),
      .i_read(i_read), .i_address(i_address), .i_waitrequest(i_waitrequest),
      .i_readdatavalid(i_readdatavalid), .i_readdata(i_readdata),
      .d_read(d_read), .d_write(d_write), .d_address(d_address),
      .d_byteenable(d_byteenable), .d_writedata(d_writedata),
      .d_waitrequest(d_waitrequest), .d_readdatavalid(d_readdatavalid), .d_readdata(d_readdata),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .contention_count(contention_count), .wp_clear(wp_clear), .wp_violation(wp_violation)
   );

   // Narrow-counter instance sharing the same stimulus, used for saturation.
   program_memory_arbiter #(.CNT_W(4)) dutSmall (
      .clk(clk), .reset_n(reset_n), .freeze(freeze),
      .i_read(i_read), .i_address(i_address), .i_waitrequest(sIWait),
      .i_readdatavalid(sIRv), .i_readdata(sIRdata),
      .d_read(d_read), .d_write(d_write), .d_address(d_address),
      .d_byteenable(d_byteenable), .d_writedata(d_writedata),
      .d_waitrequest(sDWait), .d_readdatavalid(sDRv), .d_readdata(sDRdata),
      .mem_address(sAddr), .mem_byteenable(sBe), .mem_chipselect(sCs),
      .mem_write(sWe), .mem_writedata(sWdata), .mem_readdata(mem_readdata),
      .contention_count(sCount), .wp_clear(wp_clear), .wp_violation(sWp)
   );

   // Memory model: byte-lane writes, reads return one cycle after the address.
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_byteenable[b]) memArr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
         end else begin
            mem_readdata <= memArr[mem_address];
         end
      end
   end

   typedef struct {
      logic        frz, iRd, dRd, dWr;
      logic [12:0] iAddr, dAddr;
      logic [3:0]  dBe;
      logic [31:0] dWdata;
      logic        eIWait, eDWait, eCs, eWe;
      logic [12:0] eAddr;
      logic [3:0]  eBe;
      logic        eIRv, eDRv;
      logic [31:0] eRdata;
      logic [15:0] eCnt;
   } vec_t;

   vec_t vecs [17];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      freeze       = v.frz;
      i_read       = v.iRd;
      d_read       = v.dRd;
      d_write      = v.dWr;
      i_address    = v.iAddr;
      d_address    = v.dAddr;
      d_byteenable = v.dBe;
      d_writedata  = v.dWdata;
   endtask

   task automatic idleInputs();
      freeze = 0; i_read = 0; d_read = 0; d_write = 0; wp_clear = 0;
      i_address = '0; d_address = '0; d_byteenable = '0; d_writedata = '0;
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      idleInputs();
      @(negedge clk);
      checkOutput("rst iRvalid", {31'd0, i_readdatavalid}, 32'd0);
      checkOutput("rst dRvalid", {31'd0, d_readdatavalid}, 32'd0);
      checkOutput("rst count", {16'd0, contention_count}, 32'd0);
      checkOutput("rst wp", {31'd0, wp_violation}, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      for (int a = 0; a < 8192; a++) memArr[a] = '0;
      memArr[13'h0010] = 32'hDEADBEEF;
      memArr[13'h0020] = 32'h20202020;
      memArr[13'h0030] = 32'h30303030;
      memArr[13'h0040] = 32'h40404040;
      memArr[13'h1800] = 32'hAABBCCDD;
      mem_readdata = '0;

      vecs[0]  = '{0,0,0,0, 13'h0,   13'h0,    4'h0, 32'h0,        1,1,0,0, 13'h0,    4'h0, 0,0, 32'h0,        16'd0};
      vecs[1]  = '{0,1,0,0, 13'h10,  13'h0,    4'h0, 32'h0,        0,1,1,0, 13'h10,   4'hF, 0,0, 32'h0,        16'd0};
      vecs[2]  = '{0,0,0,0, 13'h0,   13'h0,    4'h0, 32'h0,        1,1,0,0, 13'h0,    4'h0, 1,0, 32'hDEADBEEF, 16'd0};
      vecs[3]  = '{0,1,1,0, 13'h20,  13'h30,   4'hF, 32'h0,        1,0,1,0, 13'h30,   4'hF, 0,0, 32'h0,        16'd0};
      vecs[4]  = '{0,1,1,0, 13'h20,  13'h30,   4'hF, 32'h0,        0,1,1,0, 13'h20,   4'hF, 0,1, 32'h30303030, 16'd1};
      vecs[5]  = '{0,1,1,0, 13'h20,  13'h30,   4'hF, 32'h0,        1,0,1,0, 13'h30,   4'hF, 1,0, 32'h20202020, 16'd2};
      vecs[6]  = '{0,0,0,1, 13'h0,   13'h1800, 4'h3, 32'h12345678, 1,0,1,1, 13'h1800, 4'h3, 0,1, 32'h30303030, 16'd3};
      vecs[7]  = '{0,0,1,0, 13'h0,   13'h1800, 4'hF, 32'h0,        1,0,1,0, 13'h1800, 4'hF, 0,0, 32'h0,        16'd3};
      vecs[8]  = '{0,0,0,0, 13'h0,   13'h0,    4'h0, 32'h0,        1,1,0,0, 13'h0,    4'h0, 0,1, 32'hAABB5678, 16'd3};
      vecs[9]  = '{0,0,1,1, 13'h0,   13'h1801, 4'hF, 32'h0BADF00D, 1,0,1,1, 13'h1801, 4'hF, 0,0, 32'h0,        16'd3};
      vecs[10] = '{1,1,1,0, 13'h40,  13'h1801, 4'hF, 32'h0,        1,1,0,0, 13'h0,    4'h0, 0,0, 32'h0,        16'd3};
      vecs[11] = '{1,1,1,0, 13'h40,  13'h1801, 4'hF, 32'h0,        1,1,0,0, 13'h0,    4'h0, 0,0, 32'h0,        16'd3};
      vecs[12] = '{1,1,1,0, 13'h40,  13'h1801, 4'hF, 32'h0,        1,1,0,0, 13'h0,    4'h0, 0,0, 32'h0,        16'd3};
      vecs[13] = '{0,1,1,0, 13'h40,  13'h1801, 4'hF, 32'h0,        0,1,1,0, 13'h40,   4'hF, 0,0, 32'h0,        16'd3};
      vecs[14] = '{0,0,0,0, 13'h0,   13'h0,    4'h0, 32'h0,        1,1,0,0, 13'h0,    4'h0, 1,0, 32'h40404040, 16'd4};
      vecs[15] = '{0,0,1,0, 13'h0,   13'h1801, 4'hF, 32'h0,        1,0,1,0, 13'h1801, 4'hF, 0,0, 32'h0,        16'd4};
      vecs[16] = '{0,0,0,0, 13'h0,   13'h0,    4'h0, 32'h0,        1,1,0,0, 13'h0,    4'h0, 0,1, 32'h0BADF00D, 16'd4};

      doReset();

      // Table: single reads, ties, partial write, freeze and release.
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput($sformatf("v%0d iWait", i), {31'd0, i_waitrequest}, {31'd0, vecs[i].eIWait});
         checkOutput($sformatf("v%0d dWait", i), {31'd0, d_waitrequest}, {31'd0, vecs[i].eDWait});
         checkOutput($sformatf("v%0d cs", i), {31'd0, mem_chipselect}, {31'd0, vecs[i].eCs});
         checkOutput($sformatf("v%0d we", i), {31'd0, mem_write}, {31'd0, vecs[i].eWe});
         checkOutput($sformatf("v%0d iRvalid", i), {31'd0, i_readdatavalid}, {31'd0, vecs[i].eIRv});
         checkOutput($sformatf("v%0d dRvalid", i), {31'd0, d_readdatavalid}, {31'd0, vecs[i].eDRv});
         checkOutput($sformatf("v%0d count", i), {16'd0, contention_count}, {16'd0, vecs[i].eCnt});
         if (vecs[i].eCs) begin
            checkOutput($sformatf("v%0d addr", i), {19'd0, mem_address}, {19'd0, vecs[i].eAddr});
            checkOutput($sformatf("v%0d be", i), {28'd0, mem_byteenable}, {28'd0, vecs[i].eBe});
         end
         if (vecs[i].eIRv) checkOutput($sformatf("v%0d iRdata", i), i_readdata, vecs[i].eRdata);
         if (vecs[i].eDRv) checkOutput($sformatf("v%0d dRdata", i), d_readdata, vecs[i].eRdata);
         @(posedge clk);
         #1;
      end

      // Both ports hammering from reset: strict alternation and counter saturation.
      doReset();
      i_read = 1; i_address = 13'h10;
      d_read = 1; d_address = 13'h20; d_byteenable = 4'hF;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checkOutput($sformatf("rr%0d iWait", k), {31'd0, i_waitrequest}, (k % 2 == 0) ? 32'd0 : 32'd1);
         checkOutput($sformatf("rr%0d dWait", k), {31'd0, d_waitrequest}, (k % 2 == 0) ? 32'd1 : 32'd0);
         if (k > 0) begin
            checkOutput($sformatf("rr%0d iRvalid", k), {31'd0, i_readdatavalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr%0d dRvalid", k), {31'd0, d_readdatavalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
         end
         checkOutput($sformatf("rr%0d count", k), {16'd0, contention_count}, 32'(k));
         checkOutput($sformatf("rr%0d count4", k), {28'd0, sCount}, (k > 15) ? 32'd15 : 32'(k));
         @(posedge clk);
         #1;
      end
      idleInputs();
      @(negedge clk);
      checkOutput("rr end count", {16'd0, contention_count}, 32'd20);
      checkOutput("rr end count4", {28'd0, sCount}, 32'd15);

      // Reset while a read is in flight drops its valid.
      @(posedge clk);
      #1 i_read = 1; i_address = 13'h10;
      @(negedge clk);
      checkOutput("midrst iWait", {31'd0, i_waitrequest}, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b0; i_read = 0;
      #1 checkOutput("midrst iRvalid", {31'd0, i_readdatavalid}, 32'd0);
      checkOutput("midrst count", {16'd0, contention_count}, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;

`ifdef PMA_WRITE_PROTECT_EN
      // Protected write is acknowledged but suppressed; set beats a same-cycle clear.
      d_write = 1; d_address = 13'h0100; d_byteenable = 4'hF; d_writedata = 32'hFFFFFFFF;
      @(negedge clk);
      checkOutput("wp dWait", {31'd0, d_waitrequest}, 32'd0);
      checkOutput("wp we", {31'd0, mem_write}, 32'd0);
      checkOutput("wp cs", {31'd0, mem_chipselect}, 32'd0);
      checkOutput("wp before", {31'd0, wp_violation}, 32'd0);
      @(posedge clk);
      #1 wp_clear = 1;
      @(negedge clk);
      checkOutput("wp set", {31'd0, wp_violation}, 32'd1);
      @(posedge clk);
      #1 d_write = 0;
      @(negedge clk);
      checkOutput("wp set wins", {31'd0, wp_violation}, 32'd1);
      @(posedge clk);
      #1 wp_clear = 0; d_write = 1; d_address = 13'h1000;
      @(negedge clk);
      checkOutput("wp cleared", {31'd0, wp_violation}, 32'd0);
      checkOutput("wp limit we", {31'd0, mem_write}, 32'd1);
      @(posedge clk);
      #1 d_write = 0;
      @(negedge clk);
      checkOutput("wp limit flag", {31'd0, wp_violation}, 32'd0);
`else
      // Without protection, low addresses are writable and the flag stays low.
      d_write = 1; d_address = 13'h0100; d_byteenable = 4'hF; d_writedata = 32'hFFFFFFFF;
      wp_clear = 1;
      @(negedge clk);
      checkOutput("nowp dWait", {31'd0, d_waitrequest}, 32'd0);
      checkOutput("nowp we", {31'd0, mem_write}, 32'd1);
      checkOutput("nowp cs", {31'd0, mem_chipselect}, 32'd1);
      @(posedge clk);
      #1 d_write = 0; wp_clear = 0;
      @(negedge clk);
      checkOutput("nowp flag", {31'd0, wp_violation}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/program_memory_arbiter.md
Name: program_memory_arbiter

Overview:
- Shares the single-port 8192x32 on-chip program memory between the CPU instruction master (read-only) and the CPU data master (read/write).
- Each cycle, grants at most one Avalon-MM access using two-way round-robin, and drives the memory port's address, byteenable, chipselect, write and writedata.
- Returns 1-cycle-latency read data to the requester that issued the read.
- Sits between the CPU masters and the program memory instance, replacing the direct dual-slave hookup.

Parameters:
- ADDR_W, 13, word-address width of the memory and both ports.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- CNT_W, 16, width of the saturating contention counter.
- WP_LIMIT, 13'h1000, first writable word address; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- freeze  in  1  when high, no new grants are issued.
- i_read  in  1  instruction port read request.
- i_address  in  ADDR_W  instruction port word address.
- i_waitrequest  out  1  instruction port stall.
- i_readdatavalid  out  1  instruction port read data valid.
- i_readdata  out  DATA_W  instruction port read data.
- d_read  in  1  data port read request.
- d_write  in  1  data port write request.
- d_address  in  ADDR_W  data port word address.
- d_byteenable  in  DATA_W/8  data port byte lanes.
- d_writedata  in  DATA_W  data port write data.
- d_waitrequest  out  1  data port stall.
- d_readdatavalid  out  1  data port read data valid.
- d_readdata  out  DATA_W  data port read data.
- mem_address  out  ADDR_W  memory address.
- mem_byteenable  out  DATA_W/8  memory byte lanes.
- mem_chipselect  out  1  memory select.
- mem_write  out  1  memory write.
- mem_writedata  out  DATA_W  memory write data.
- mem_readdata  in  DATA_W  memory read data, valid 1 cycle after the address.
- contention_count  out  CNT_W  saturating count of cycles in which both ports requested.
- wp_clear  in  1  clears wp_violation.
- wp_violation  out  1  sticky write-protect flag.

Behaviour:
- Request definitions: i_req = i_read; d_req = d_read | d_write. If d_read and d_write are both high, the access is treated as a write.
- Arbitration is combinational within the cycle, from the requests and the last_grant register.
  - Only one port requesting: that port wins.
  - Both requesting: the port not recorded in last_grant wins.
  - last_grant updates on the clock edge whenever a grant occurs.
- Winner's waitrequest is low in the grant cycle. The loser's waitrequest is high; a non-requesting port's waitrequest is also high.
- While freeze is high:
  - No grant; both waitrequests high; mem_chipselect = 0.
  - last_grant and contention_count hold.
- Memory outputs follow the granted port: address, byteenable (all ones for the instruction port), writedata, chipselect = 1, and mem_write = 1 only for a granted data write. When there is no grant, mem_chipselect = 0 and mem_write = 0.
- Read return: a granted read at cycle N sets the winner's rvalid register, so readdatavalid is high at cycle N+1 for exactly 1 cycle. Back-to-back reads are pipelined: 1 grant per cycle and 1 valid per cycle.
- i_readdata and d_readdata are both wired directly to mem_readdata; they are qualified only by readdatavalid.
- A write completes in its grant cycle and produces no readdatavalid.
- contention_count increments in each unfrozen cycle where i_req & d_req, and saturates at all ones.
- Fairness: with both ports continuously requesting, grants alternate I, D, I, D… No port waits more than 1 cycle while the other holds the memory.
- Reset values (asynchronous on reset_n low):
  - last_grant = D, so the instruction port wins the first tie.
  - Both rvalid registers = 0; contention_count = 0; wp_violation = 0.
- Reset mid-read: the pending readdatavalid is dropped.
- After reset release, the first access is granted in the first cycle a request is present.

Optional Feature:
- Macro: PMA_WRITE_PROTECT_EN.
- Defined:
  - A granted data write with d_address < WP_LIMIT is still acknowledged (d_waitrequest low), but mem_write = 0 and mem_chipselect = 0.
  - wp_violation sets the next cycle and stays set until a wp_clear pulse.
  - If a violation and wp_clear occur in the same cycle, set wins.
- Undefined: all writes pass through to memory; wp_violation is tied 0 and wp_clear is ignored.

Test Plan:
- Reset, then an i_read to 0x0010 with the memory holding 0xDEADBEEF there -> i_waitrequest = 0 in cycle 0; i_readdatavalid = 1 in cycle 1 with i_readdata = 0xDEADBEEF; d_readdatavalid stays 0.
- i_read and d_read held high for 6 cycles from reset -> grants I, D, I, D, I, D; each readdatavalid toggles 1 cycle later; contention_count = 6.
- d_write of 0x12345678 to 0x1800 with byteenable 0x3, then d_read of 0x1800 -> mem_write pulses for 1 cycle; the read returns low half-word 0x5678 and the upper bytes unchanged.
- freeze held high for 3 cycles while both ports request -> both waitrequests high, mem_chipselect = 0, contention_count unchanged; after release, the port not in last_grant wins first.
- contention_count preloaded near saturation (CNT_W = 4, both ports requesting 20 cycles) -> value stops at 0xF.
- With PMA_WRITE_PROTECT_EN defined, a d_write to 0x0100 -> d_waitrequest = 0, mem_write = 0, wp_violation = 1 the next cycle; a wp_clear pulse returns it to 0.
